// File: rtl/accum_readout_ctrl.sv
// accum_readout_ctrl: freezes the accumulator and streams its bytes out through the datapath mux
module accum_readout_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 1,
    parameter bit          INCLUDE_CARRY = 1'b1
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       start_i,
    input  logic       abort_i,
    input  logic [7:0] mux_data_i,
    output logic [2:0] mux_sel_o,
    output logic       acc_hold_o,
    output logic [7:0] out_data_o,
    output logic       out_valid_o,
    input  logic       out_ready_i,
    output logic [1:0] out_index_o,
    output logic       busy_o,
    output logic       done_o
);
    localparam logic [2:0] MUX_SEL_REGISTER_2_LSB = 3'd0;
    localparam logic [2:0] MUX_SEL_REGISTER_2_MSB = 3'd1;
    localparam logic [2:0] MUX_SEL_COUNTER_VALUE  = 3'd2;
    localparam logic [2:0] MUX_SEL_COUNTER_CARRY  = 3'd3;
    localparam logic [1:0] LAST_IDX               = INCLUDE_CARRY ? 2'd3 : 2'd2;
    localparam logic [3:0] SETTLE_LAST            = 4'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, HOLD, SELECT, PRESENT, DONE} state_t;

    state_t     state_q;
    logic [3:0] settle_q;
    logic [1:0] idx_q;
    logic [2:0] mux_sel_q;
    logic       acc_hold_q;
    logic [7:0] out_data_q;
    logic       out_valid_q;
    logic [1:0] out_index_q;
    logic       busy_q;
    logic       done_q;

    function automatic logic [2:0] sel_code(input logic [1:0] i);
        return i == 2'd0 ? MUX_SEL_REGISTER_2_LSB :
               i == 2'd1 ? MUX_SEL_REGISTER_2_MSB :
               i == 2'd2 ? MUX_SEL_COUNTER_VALUE  : MUX_SEL_COUNTER_CARRY;
    endfunction

    // Readout sequencer; abort outranks every transition, including a same-cycle handshake
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            settle_q    <= 4'd0;
            idx_q       <= 2'd0;
            mux_sel_q   <= MUX_SEL_REGISTER_2_LSB;
            acc_hold_q  <= 1'b0;
            out_data_q  <= 8'd0;
            out_valid_q <= 1'b0;
            out_index_q <= 2'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else if (abort_i && state_q != IDLE) begin
            state_q     <= IDLE;
            settle_q    <= 4'd0;
            idx_q       <= 2'd0;
            mux_sel_q   <= MUX_SEL_REGISTER_2_LSB;
            acc_hold_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: if (start_i && !abort_i) begin
                    state_q    <= HOLD;
                    acc_hold_q <= 1'b1;
                    busy_q     <= 1'b1;
                    idx_q      <= 2'd0;
                end
                HOLD: begin
                    state_q   <= SELECT;
                    mux_sel_q <= sel_code(2'd0);
                    settle_q  <= 4'd0;
                end
                SELECT: if (settle_q == SETTLE_LAST) begin
                    state_q     <= PRESENT;
                    settle_q    <= 4'd0;
                    out_data_q  <= mux_data_i;
                    out_valid_q <= 1'b1;
                    out_index_q <= idx_q;
                end else begin
                    settle_q <= settle_q + 4'd1;
                end
                PRESENT: if (out_ready_i) begin
                    out_valid_q <= 1'b0;
                    if (idx_q == LAST_IDX) begin
                        state_q    <= DONE;
                        done_q     <= 1'b1;
                        acc_hold_q <= 1'b0;
                    end else begin
                        state_q   <= SELECT;
                        idx_q     <= idx_q + 2'd1;
                        mux_sel_q <= sel_code(idx_q + 2'd1);
                    end
                end
                DONE: begin
                    state_q   <= IDLE;
                    busy_q    <= 1'b0;
                    idx_q     <= 2'd0;
                    mux_sel_q <= MUX_SEL_REGISTER_2_LSB;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mux_sel_o   = mux_sel_q;
    assign acc_hold_o  = acc_hold_q;
    assign out_data_o  = out_data_q;
    assign out_valid_o = out_valid_q;
    assign out_index_o = out_index_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
endmodule

// File: tb/tb_accum_readout_ctrl.sv
// tb_accum_readout_ctrl: scoreboard bench over three configurations of the readout sequencer
module tb_accum_readout_ctrl;
    localparam logic [2:0] SEL_LSB = 3'd0;
    localparam logic [2:0] SEL_MSB = 3'd1;
    localparam logic [2:0] SEL_CV  = 3'd2;
    localparam logic [2:0] SEL_CC  = 3'd3;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [2:0]      start_v = '0, abort_v = '0, ready_v = '1, ff_v = '0;
    logic [2:0]      hold_v, valid_v, busy_v, done_v;
    logic [2:0][7:0] mdata, odata;
    logic [2:0][2:0] msel;
    logic [2:0][1:0] oidx;
    logic [10:0]     exp_q [3][$];
    int              n_chk = 0, n_fail = 0;
    bit              saw_cc = 1'b0;

    always #5 clk = ~clk;

    function automatic logic [7:0] mux_model(input logic [2:0] s);
        return s == SEL_LSB ? 8'h34 : s == SEL_MSB ? 8'h12 : s == SEL_CV ? 8'hA5 : s == SEL_CC ? 8'h01 : 8'h00;
    endfunction

    // Instance 0: settle 1 with carry; 1: settle 1 without carry; 2: settle 4 with carry
    for (genvar g = 0; g < 3; g++) begin : dut
        assign mdata[g] = ff_v[g] ? 8'hFF : mux_model(msel[g]);
        accum_readout_ctrl #(.SETTLE_CYCLES(g == 2 ? 4 : 1), .INCLUDE_CARRY(g != 1)) u_dut (
            .clk_i(clk), .reset_i(reset), .start_i(start_v[g]), .abort_i(abort_v[g]),
            .mux_data_i(mdata[g]), .mux_sel_o(msel[g]), .acc_hold_o(hold_v[g]),
            .out_data_o(odata[g]), .out_valid_o(valid_v[g]), .out_ready_i(ready_v[g]),
            .out_index_o(oidx[g]), .busy_o(busy_v[g]), .done_o(done_v[g])
        );
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Pops the scoreboard on every byte that will be accepted at the coming edge
    always @(negedge clk) begin
        if (msel[1] == SEL_CC) saw_cc = 1'b1;
        for (int g = 0; g < 3; g++) begin
            if (valid_v[g] && ready_v[g] && !abort_v[g] && !reset) begin
                logic [10:0] e;
                e = exp_q[g].size() != 0 ? exp_q[g].pop_front() : 11'd0;
                check($sformatf("byte_dut%0d", g), {1'b1, oidx[g], odata[g]}, e);
            end
        end
    end

    task automatic push_seq(input int g, input bit carry);
        exp_q[g].push_back({1'b1, 2'd0, 8'h34});
        exp_q[g].push_back({1'b1, 2'd1, 8'h12});
        exp_q[g].push_back({1'b1, 2'd2, 8'hA5});
        if (carry) exp_q[g].push_back({1'b1, 2'd3, 8'h01});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic kick(input int g, input bit carry);
        push_seq(g, carry);
        start_v[g] = 1'b1;
        tick();
        start_v[g] = 1'b0;
    endtask

    task automatic wait_done(input int g);
        bit seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            tick();
            seen = done_v[g];
        end
        check("done_seen", seen, 1);
        check("sb_drained", exp_q[g].size(), 0);
    endtask

    task automatic check_idle(input int g, input string tag);
        check({tag, "_sel"}, msel[g], SEL_LSB);
        check({tag, "_hold"}, hold_v[g], 0);
        check({tag, "_valid"}, valid_v[g], 0);
        check({tag, "_busy"}, busy_v[g], 0);
        check({tag, "_done"}, done_v[g], 0);
        check({tag, "_data"}, odata[g], 0);
        check({tag, "_index"}, oidx[g], 0);
    endtask

    // Cycle-exact trace with out_ready high: byte k valid after E(2k+2), done after E(2n+1)
    task automatic run_timed(input int g, input int n);
        kick(g, n == 4);
        check("hold_e0", hold_v[g], 1);
        for (int k = 1; k <= 2 * n + 2; k++) begin
            tick();
            check($sformatf("hold_e%0d", k), hold_v[g], k <= 2 * n);
            check($sformatf("done_e%0d", k), done_v[g], k == 2 * n + 1);
            check($sformatf("valid_e%0d", k), valid_v[g], (k % 2 == 0) && k <= 2 * n);
            check($sformatf("busy_e%0d", k), busy_v[g], k <= 2 * n + 1);
        end
        check("sb_timed", exp_q[g].size(), 0);
    endtask

    initial begin
        bit any_busy;
        #2;
        for (int g = 0; g < 3; g++) check_idle(g, "rst");
        #6 reset = 1'b0;
        tick();

        run_timed(0, 4);
        run_timed(1, 3);
        check("no_carry_sel", saw_cc, 0);

        // Backpressure on byte 1 while the mux output is corrupted
        kick(0, 1);
        tick(); tick(); tick();
        ready_v[0] = 1'b0;
        tick();
        ff_v[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_valid", valid_v[0], 1);
            check("bp_data", odata[0], 8'h12);
            check("bp_index", oidx[0], 1);
        end
        ff_v[0] = 1'b0;
        ready_v[0] = 1'b1;
        wait_done(0);

        // Long settle: only the mux value in the last select cycle is captured
        kick(2, 1);
        tick();
        ff_v[2] = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            check($sformatf("settle_sel%0d", k), msel[2], SEL_LSB);
            check($sformatf("settle_valid%0d", k), valid_v[2], 0);
            if (k == 4) ff_v[2] = 1'b0;
            else tick();
        end
        tick();
        check("settle_cap_valid", valid_v[2], 1);
        check("settle_cap_data", odata[2], 8'h34);
        wait_done(2);

        // Abort during byte 2 with ready high: byte is dropped, no done
        kick(0, 1);
        for (int k = 1; k <= 6; k++) tick();
        check("ab_pre_index", oidx[0], 2);
        abort_v[0] = 1'b1;
        tick();
        abort_v[0] = 1'b0;
        check("ab_valid", valid_v[0], 0);
        check("ab_hold", hold_v[0], 0);
        check("ab_busy", busy_v[0], 0);
        check("ab_done", done_v[0], 0);
        check("ab_sb_left", exp_q[0].size(), 2);
        exp_q[0].delete();
        tick();
        check("ab_done_late", done_v[0], 0);
        start_v[0] = 1'b1;
        abort_v[0] = 1'b1;
        tick();
        start_v[0] = 1'b0;
        abort_v[0] = 1'b0;
        check("ab_idle_busy", busy_v[0], 0);
        check("ab_idle_hold", hold_v[0], 0);
        tick();
        check("ab_idle_busy2", busy_v[0], 0);
        kick(0, 1);
        wait_done(0);

        // Asynchronous reset in the middle of byte 1 select
        kick(2, 1);
        for (int k = 1; k <= 7; k++) tick();
        check("rs_pre_sel", msel[2], SEL_MSB);
        #2 reset = 1'b1;
        #1;
        check_idle(2, "rs");
        exp_q[2].delete();
        #2 reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("rs_no_done", done_v[2], 0);
        end
        check("rs_busy", busy_v[2], 0);

        // Start pulses while busy must not queue a second readout
        kick(0, 1);
        tick();
        tick();
        start_v[0] = 1'b1;
        tick();
        start_v[0] = 1'b0;
        tick();
        tick();
        start_v[0] = 1'b1;
        tick();
        start_v[0] = 1'b0;
        wait_done(0);
        tick();
        any_busy = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            any_busy |= busy_v[0] | valid_v[0];
        end
        check("no_second_seq", any_busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
